// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mult_pkg;

    localparam int MUL_W       = 16;
    localparam int PROD_W      = 32;
    localparam int MUL_LAT_DEF = 17;
    localparam int CNT_W       = $clog2(MUL_LAT_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter width for a given multiplier latency; never below one bit.
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; prio points at the requester that wins a tie.
// Latency: grant is combinational from req; prio updates one cycle after advance.
// Backpressure: none of its own; the caller masks req when it cannot accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // prio = 0 means requester 0 wins a tie, 1 means requester 1 wins.
    logic prio;

    // One-hot grant: a lone requester always wins, a tie goes to prio.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Hand priority to the other requester whenever a grant is consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier between two requesters with round-robin grant.
// Latency: handshake to rsp pulse is MUL_LAT+2 cycles; one op every MUL_LAT+3 cycles.
// Backpressure: ready only in IDLE for the granted requester; responses cannot be stalled.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int MUL_LAT = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic                req1_valid,
    input  logic [MUL_W-1:0]    req0_a,
    input  logic [MUL_W-1:0]    req0_b,
    input  logic [MUL_W-1:0]    req1_a,
    input  logic [MUL_W-1:0]    req1_b,
    output logic                req0_ready,
    output logic                req1_ready,
    output logic                rsp0_valid,
    output logic                rsp1_valid,
    output logic [PROD_W-1:0]   rsp_data,
    output logic                mul_st,
    output logic [MUL_W-1:0]    mul_m1,
    output logic [MUL_W-1:0]    mul_m2,
    input  logic [PROD_W-1:0]   mul_resul,
    output logic                busy
);

    localparam int            CW       = cnt_width(MUL_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner;
    logic [1:0]    arb_req;
    logic [1:0]    gnt;
    logic          hs0;
    logic          hs1;

    // Requests are only visible to the arbiter while idle and out of reset,
    // so ready is naturally low in every other state.
    assign arb_req    = {req1_valid, req0_valid} & {2{(state == IDLE) && rst}};
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign hs0        = req0_valid && req0_ready;
    assign hs1        = req1_valid && req1_ready;
    assign busy       = (state != IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (hs0 || hs1),
        .gnt     (gnt)
    );

    // Operation sequencer: latch operands, pulse start, count latency, return product.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            mul_st     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            mul_m1     <= '0;
            mul_m2     <= '0;
            rsp_data   <= '0;
        end else begin
            mul_st     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs0 || hs1) begin
                        mul_m1 <= hs1 ? req1_a : req0_a;
                        mul_m2 <= hs1 ? req1_b : req0_b;
                        owner  <= hs1;
                        mul_st <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    cnt   <= CNT_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rsp_data   <= mul_resul;
                        rsp0_valid <= ~owner;
                        rsp1_valid <= owner;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
